// File: rtl/strip_pkg.sv
// Shared types and helpers for the strip frame loader.
package strip_pkg;

  localparam int unsigned LED_ADDR_W = 9;
  localparam int unsigned COLOR_W    = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/strip_position_counter.sv
// LED position / strip index pair walking the frame in raster order.
module strip_position_counter
  import strip_pkg::*;
#(
  parameter int unsigned STRIP_COUNT = 8,
  parameter int unsigned LED_COUNT   = 240,
  parameter int unsigned StripW      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,    // back to strip 0, LED 0
  input  logic                  restart_i,  // position following strip 0, LED 0
  input  logic                  advance_i,  // step past the current position
  output logic [LED_ADDR_W-1:0] led_pos_o,
  output logic [StripW-1:0]     strip_idx_o,
  output logic                  last_o
);

  localparam logic [LED_ADDR_W-1:0] LastPos   = LED_ADDR_W'(LED_COUNT - 1);
  localparam logic [StripW-1:0]     LastStrip = StripW'(STRIP_COUNT - 1);

  logic [LED_ADDR_W-1:0] pos_q, pos_d, base_pos, step_pos;
  logic [StripW-1:0]     strip_q, strip_d, base_strip, step_strip;

  // Next position: step from either the current slot or from (0,0) on restart.
  always_comb begin
    base_pos   = restart_i ? '0 : pos_q;
    base_strip = restart_i ? '0 : strip_q;
    if (base_pos == LastPos) begin
      step_pos   = '0;
      step_strip = base_strip + 1'b1;
    end else begin
      step_pos   = base_pos + 1'b1;
      step_strip = base_strip;
    end
    pos_d   = pos_q;
    strip_d = strip_q;
    if (clear_i) begin
      pos_d   = '0;
      strip_d = '0;
    end else if (restart_i || advance_i) begin
      pos_d   = step_pos;
      strip_d = step_strip;
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pos_q   <= '0;
      strip_q <= '0;
    end else begin
      pos_q   <= pos_d;
      strip_q <= strip_d;
    end
  end

  assign led_pos_o   = pos_q;
  assign strip_idx_o = strip_q;
  assign last_o      = (pos_q == LastPos) && (strip_q == LastStrip);

endmodule

// File: rtl/strip_frame_loader.sv
// Frame sequencer: distributes a raster pixel stream over the strip pixel RAMs.
module strip_frame_loader
  import strip_pkg::*;
#(
  parameter int unsigned STRIP_COUNT = 8,
  parameter int unsigned LED_COUNT   = 240
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   pixel_valid_i,
  output logic                   pixel_ready_o,
  input  logic                   pixel_sof_i,
  input  logic [COLOR_W-1:0]     pixel_r_i,
  input  logic [COLOR_W-1:0]     pixel_g_i,
  input  logic [COLOR_W-1:0]     pixel_b_i,
  output logic [COLOR_W-1:0]     pixel_r_o,
  output logic [COLOR_W-1:0]     pixel_g_o,
  output logic [COLOR_W-1:0]     pixel_b_o,
  output logic [LED_ADDR_W-1:0]  led_address_o,
  output logic [STRIP_COUNT-1:0] led_address_valid_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   sync_err_o
);

  localparam int unsigned StripW      = clog2_min1(STRIP_COUNT);
  localparam bit          SinglePixel = (STRIP_COUNT * LED_COUNT) == 1;

  state_e                state_q, state_d;
  logic                  accept;
  logic                  cnt_clear, cnt_restart, cnt_advance, cnt_last;
  logic [LED_ADDR_W-1:0] led_pos;
  logic [StripW-1:0]     strip_idx;

  logic                   wr;
  logic [StripW-1:0]      wr_strip;
  logic [LED_ADDR_W-1:0]  wr_addr;
  logic                   err;
  logic [STRIP_COUNT-1:0] strobe_d, strobe_q;
  logic [LED_ADDR_W-1:0]  addr_q;
  logic [COLOR_W-1:0]     r_q, g_q, b_q;
  logic                   err_q;

  assign pixel_ready_o = enable_i && (state_q != StDone);
  assign accept        = pixel_valid_i && pixel_ready_o;

  strip_position_counter #(
    .STRIP_COUNT (STRIP_COUNT),
    .LED_COUNT   (LED_COUNT),
    .StripW      (StripW)
  ) u_pos (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (cnt_clear),
    .restart_i   (cnt_restart),
    .advance_i   (cnt_advance),
    .led_pos_o   (led_pos),
    .strip_idx_o (strip_idx),
    .last_o      (cnt_last)
  );

  // Next state, counter control and write decode.
  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b0;
    cnt_restart = 1'b0;
    cnt_advance = 1'b0;
    wr          = 1'b0;
    wr_strip    = strip_idx;
    wr_addr     = led_pos;
    err         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (pixel_sof_i) begin
            wr       = 1'b1;
            wr_strip = '0;
            wr_addr  = '0;
            if (SinglePixel) begin
              state_d = StDone;
            end else begin
              cnt_restart = 1'b1;
              state_d     = StLoad;
            end
          end else begin
            // Orphan pixel: swallowed so the source can drain to the next frame.
            err = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          wr = 1'b1;
          if (pixel_sof_i) begin
            // Early start of frame: restart the frame with this pixel.
            err         = 1'b1;
            wr_strip    = '0;
            wr_addr     = '0;
            cnt_restart = 1'b1;
          end else if (cnt_last) begin
            cnt_clear = 1'b1;
            state_d   = StDone;
          end else begin
            cnt_advance = 1'b1;
          end
        end
      end
      StDone: begin
        cnt_clear = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  // One-hot strobe for the addressed strip.
  always_comb begin
    strobe_d = '0;
    for (int unsigned i = 0; i < STRIP_COUNT; i++) begin
      strobe_d[i] = wr && (wr_strip == StripW'(i));
    end
  end

  // State and output registers; data/address hold between writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      strobe_q <= '0;
      addr_q   <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      err_q    <= err;
      if (wr) begin
        addr_q <= wr_addr;
        r_q    <= pixel_r_i;
        g_q    <= pixel_g_i;
        b_q    <= pixel_b_i;
      end
    end
  end

  assign pixel_r_o           = r_q;
  assign pixel_g_o           = g_q;
  assign pixel_b_o           = b_q;
  assign led_address_o       = addr_q;
  assign led_address_valid_o = strobe_q;
  assign sync_err_o          = err_q;
  assign busy_o              = (state_q == StLoad);
  assign frame_done_o        = (state_q == StDone);

endmodule

// File: doc/strip_frame_loader.md
Name: strip_frame_loader

Overview:
- Single-clock frame sequencer feeding the per-strip WS2812 pixel RAM write ports.
- Accepts a raster pixel stream with a valid/ready handshake and a start-of-frame marker.
- Distributes pixels in order across STRIP_COUNT strips of LED_COUNT LEDs each, driving a shared address and RGB bus plus one write strobe per strip.
- Sits between the host pixel source (SPI/GPMC bridge) and the array of strip_ws2812 instances.

Parameters:
- STRIP_COUNT, 8, number of strips driven; range 1..16.
- LED_COUNT, 240, LEDs per strip; range 1..512, must fit 9-bit address.

Ports:
- clk_i  input  1  pixel clock; drives all logic.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- enable_i  input  1  when low, stream is back-pressured (pixel_ready_o=0).
- pixel_valid_i  input  1  source has a pixel.
- pixel_ready_o  output  1  block accepts pixel this cycle.
- pixel_sof_i  input  1  qualifies pixel as first of frame.
- pixel_r_i / pixel_g_i / pixel_b_i  input  8 each  pixel colour.
- pixel_r_o / pixel_g_o / pixel_b_o  output  8 each  registered colour to all strips.
- led_address_o  output  9  registered LED index within strip.
- led_address_valid_o  output  STRIP_COUNT  one-hot write strobe, one bit per strip.
- busy_o  output  1  high while in LOAD.
- frame_done_o  output  1  one-cycle pulse, full frame written.
- sync_err_o  output  1  one-cycle pulse, framing error.

Behaviour:
- Accept = pixel_valid_i & pixel_ready_o. pixel_ready_o = enable_i & (state != DONE).
- Reset (async, rst_n_i=0): state IDLE; led_pos=0; strip_idx=0; all outputs 0, including led_address_valid_o=0, pixel_*_o=0, busy_o=0, frame_done_o=0 and sync_err_o=0.
- Write latency: an accepted pixel appears on pixel_*_o, led_address_o and led_address_valid_o exactly 1 cycle later, for exactly 1 cycle.
- With no accept, led_address_valid_o=0 and the data/address outputs hold their last values.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - Accept with sof=1: write strip 0 address 0. If STRIP_COUNT*LED_COUNT==1, go to DONE; otherwise set led_pos=1 and go to LOAD.
  - Accept with sof=0: pixel is consumed and dropped, no write, sync_err_o pulses next cycle, stay in IDLE.
- LOAD:
  - Accept with sof=0: write strip strip_idx at address led_pos.
  - After that write: if led_pos==LED_COUNT-1, set led_pos=0 and increment strip_idx; otherwise increment led_pos.
  - Accepting the last pixel (strip_idx==STRIP_COUNT-1, led_pos==LED_COUNT-1) transitions to DONE.
  - Accept with sof=1 (premature new frame): sync_err_o pulses; the pixel is written as strip 0 address 0; led_pos=1, strip_idx=0; remain in LOAD (resync, no frame_done).
- DONE: lasts exactly 1 cycle. frame_done_o=1 during this cycle, pixel_ready_o=0. Returns to IDLE with counters cleared.
- busy_o = (state==LOAD), registered with the state.
- enable_i low:
  - Only stalls the handshake; state and counters are preserved.
  - A partially loaded frame resumes when enable_i returns high.
- Reset mid-frame: counters and state clear immediately; any write strobe in flight is cancelled (led_address_valid_o forced to 0).
- Counters:
  - led_pos is 9 bits; strip_idx is ceil(log2(STRIP_COUNT)) bits, minimum 1.
  - Comparisons use LED_COUNT-1 and STRIP_COUNT-1 sized to those widths; no wrap past STRIP_COUNT-1 can occur.
- Simultaneous DONE entry and a new sof pixel on the input: the pixel is not accepted (ready=0 in DONE). It is taken on the following IDLE cycle.

Decomposition:
- Shared package strip_pkg:
  - LED_ADDR_W=9, COLOR_W=8.
  - State encoding for IDLE/LOAD/DONE.
  - Function clog2_min1 for strip index width.
- One sub-module: strip_position_counter (led_pos/strip_idx pair with clear, advance and last-pixel flag). The FSM and output registers stay in strip_frame_loader.

Test Plan:
- Use STRIP_COUNT=2, LED_COUNT=3 for the small benches.
- Reset then idle: all outputs 0, pixel_ready_o=1 once enable_i=1.
- Full frame: 6 back-to-back pixels, sof on the first, colours 0x010203..0x060708.
  - Writes observed: strip0 at addresses 0,1,2, then strip1 at 0,1,2, each strobe one-hot and 1 cycle after its accept.
  - frame_done_o pulses one cycle after the 6th write strobe's accept cycle; busy_o falls.
- Orphan pixel in IDLE (sof=0): no strobe; sync_err_o pulses 1 cycle later; state stays IDLE.
- Resync: sof pixel at strip1 address 1 mid-frame.
  - sync_err_o pulses; write goes to strip0 address 0.
  - 5 further pixels complete the frame; frame_done_o pulses once.
- Back-pressure: drop enable_i after 2 accepts for 10 cycles with valid held high.
  - No strobes during the stall; the next accept writes strip0 address 2.
  - pixel_valid_i toggled randomly: strobes only on accept cycles.
- Async reset asserted mid-frame, between clock edges: outputs clear without a clock edge; the next sof pixel writes strip0 address 0. Also run with STRIP_COUNT=16, LED_COUNT=512: the last write is strip15 address 511.
